// File: rtl/byte_joining_pkg.sv
// Shared types and helpers for the parametrised lane joiner.
// Width helpers let the top derive its index/count widths from LANES alone.
package byte_joining_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int unsigned sel_width(input int unsigned lanes);
    return $clog2(lanes);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned lanes);
    return $clog2(lanes) + 1;
  endfunction

  // Zero or anything above the lane count means "all lanes".
  function automatic int unsigned clamp_lanes(input int unsigned req,
                                              input int unsigned lanes);
    return (req == 0 || req > lanes) ? lanes : req;
  endfunction

endpackage

// File: rtl/lane_mux_n.sv
// LANES:1 combinational selector of WIDTH-bit symbols from a flat word.
module lane_mux_n #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic [LANES*WIDTH-1:0] word,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       data
);

  // Out-of-range selects (non power-of-two LANES) yield zero.
  always_comb begin
    data = '0;
    for (int k = 0; k < LANES; k++)
      if (sel == SEL_W'(k)) data = word[k*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/byte_joining_param.sv
// Re-serialises LANES-wide words onto one WIDTH-bit stream with valid/ready
// on both sides, a runtime lane count and a one-word pending buffer.
module byte_joining_param
  import byte_joining_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = sel_width(LANES),
  parameter int CNT_W = cnt_width(LANES)
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic [LANES*WIDTH-1:0] lanes_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CNT_W-1:0]       active_lanes,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       out_lane,
  output logic                   out_last
);

  state_t                 state, state_nx;
  logic [LANES*WIDTH-1:0] act_word, act_word_nx;
  logic [LANES*WIDTH-1:0] pend_word, pend_word_nx;
  logic [CNT_W-1:0]       n_act, n_act_nx;
  logic [CNT_W-1:0]       pend_n, pend_n_nx;
  logic [SEL_W-1:0]       ptr, ptr_nx;
  logic                   pend_full, pend_full_nx;

  logic [CNT_W-1:0]       n_in;
  logic                   in_hs, out_hs, done;

  assign n_in      = CNT_W'(clamp_lanes(32'(active_lanes), LANES));
  assign in_ready  = !pend_full;
  assign in_hs     = in_valid && in_ready;
  assign out_valid = (state == SEND);
  assign out_lane  = ptr;
  assign out_last  = (CNT_W'(ptr) == n_act - CNT_W'(1));
  assign out_hs    = out_valid && out_ready;
  assign done      = out_hs && out_last;

  lane_mux_n #(
    .LANES (LANES),
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_mux (
    .word (act_word),
    .sel  (ptr),
    .data (out_data)
  );

  always_comb begin
    state_nx     = state;
    act_word_nx  = act_word;
    n_act_nx     = n_act;
    ptr_nx       = ptr;
    pend_word_nx = pend_word;
    pend_n_nx    = pend_n;
    pend_full_nx = pend_full;
    unique case (state)
      IDLE: begin
        if (in_hs) begin
          act_word_nx = lanes_in;
          n_act_nx    = n_in;
          ptr_nx      = '0;
          state_nx    = SEND;
        end
      end
      SEND: begin
        if (done) begin
          ptr_nx = '0;
          if (pend_full) begin
            act_word_nx  = pend_word;
            n_act_nx     = pend_n;
            pend_full_nx = 1'b0;
          end else if (in_hs) begin
            // Straight into ACTIVE so back-to-back words leave no gap.
            act_word_nx = lanes_in;
            n_act_nx    = n_in;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          if (out_hs) ptr_nx = ptr + SEL_W'(1);
          if (in_hs) begin
            pend_word_nx = lanes_in;
            pend_n_nx    = n_in;
            pend_full_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      act_word  <= '0;
      n_act     <= CNT_W'(LANES);
      ptr       <= '0;
      pend_word <= '0;
      pend_n    <= CNT_W'(LANES);
      pend_full <= 1'b0;
    end else begin
      state     <= state_nx;
      act_word  <= act_word_nx;
      n_act     <= n_act_nx;
      ptr       <= ptr_nx;
      pend_word <= pend_word_nx;
      pend_n    <= pend_n_nx;
      pend_full <= pend_full_nx;
    end
  end

endmodule

// File: tb/tb_byte_joining_param.sv
// Directed bench for byte_joining_param at LANES=4, WIDTH=8.
module tb_byte_joining_param;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [31:0] lanes_in;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  active_lanes;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane;
  logic        out_last;

  int total = 0;
  int bad   = 0;

  byte_joining_param #(.LANES(4), .WIDTH(8)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .lanes_in     (lanes_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .active_lanes (active_lanes),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane     (out_lane),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic sym(input string tag, input logic [7:0] d, input logic [1:0] ln,
                     input logic lst, input logic ir);
    chk({tag, ".vld"}, 32'(out_valid), 32'd1);
    chk({tag, ".dat"}, 32'(out_data), 32'(d));
    chk({tag, ".lane"}, 32'(out_lane), 32'(ln));
    chk({tag, ".last"}, 32'(out_last), 32'(lst));
    chk({tag, ".rdy"}, 32'(in_ready), 32'(ir));
  endtask

  task automatic idle(input string tag);
    chk({tag, ".vld"}, 32'(out_valid), 32'd0);
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0; lanes_in = '0; in_valid = 1'b0;
    active_lanes = 3'd4; out_ready = 1'b1;

    // reset and idle
    nx(); nx();
    idle("rst");
    chk("rst.dat", 32'(out_data), 32'h00);
    chk("rst.lane", 32'(out_lane), 32'd0);
    chk("rst.last", 32'(out_last), 32'd0);
    reset_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nx();
      idle("idle");
      chk("idle.dat", 32'(out_data), 32'h00);
    end

    // single word, all four lanes
    lanes_in = 32'hDDCCBBAA; in_valid = 1'b1;
    nx(); sym("w1.0", 8'hAA, 2'd0, 1'b0, 1'b1); in_valid = 1'b0;
    nx(); sym("w1.1", 8'hBB, 2'd1, 1'b0, 1'b1);
    nx(); sym("w1.2", 8'hCC, 2'd2, 1'b0, 1'b1);
    nx(); sym("w1.3", 8'hDD, 2'd3, 1'b1, 1'b1);
    nx(); idle("w1.end");

    // back-to-back, second word offered while the first streams (pending path)
    lanes_in = 32'h44332211; in_valid = 1'b1;
    nx(); sym("bb.11", 8'h11, 2'd0, 1'b0, 1'b1); lanes_in = 32'h88776655;
    nx(); sym("bb.22", 8'h22, 2'd1, 1'b0, 1'b0); in_valid = 1'b0;
    nx(); sym("bb.33", 8'h33, 2'd2, 1'b0, 1'b0);
    nx(); sym("bb.44", 8'h44, 2'd3, 1'b1, 1'b0);
    nx(); sym("bb.55", 8'h55, 2'd0, 1'b0, 1'b1);
    nx(); sym("bb.66", 8'h66, 2'd1, 1'b0, 1'b1);
    nx(); sym("bb.77", 8'h77, 2'd2, 1'b0, 1'b1);
    nx(); sym("bb.88", 8'h88, 2'd3, 1'b1, 1'b1);
    nx(); idle("bb.end");

    // back-to-back, second word offered on the last lane (direct load, in_ready stays 1)
    lanes_in = 32'h44332211; in_valid = 1'b1;
    nx(); sym("dl.11", 8'h11, 2'd0, 1'b0, 1'b1); in_valid = 1'b0;
    nx(); sym("dl.22", 8'h22, 2'd1, 1'b0, 1'b1);
    nx(); sym("dl.33", 8'h33, 2'd2, 1'b0, 1'b1);
    nx(); sym("dl.44", 8'h44, 2'd3, 1'b1, 1'b1); lanes_in = 32'h88776655; in_valid = 1'b1;
    nx(); sym("dl.55", 8'h55, 2'd0, 1'b0, 1'b1); in_valid = 1'b0;
    nx(); sym("dl.66", 8'h66, 2'd1, 1'b0, 1'b1);
    nx(); sym("dl.77", 8'h77, 2'd2, 1'b0, 1'b1);
    nx(); sym("dl.88", 8'h88, 2'd3, 1'b1, 1'b1);
    nx(); idle("dl.end");

    // backpressure: hold AA, second word to PENDING, third waits for promotion
    lanes_in = 32'hDDCCBBAA; in_valid = 1'b1; out_ready = 1'b0;
    nx(); sym("bp.aa", 8'hAA, 2'd0, 1'b0, 1'b1); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nx(); sym("bp.hold", 8'hAA, 2'd0, 1'b0, 1'b1);
    end
    lanes_in = 32'h44332211; in_valid = 1'b1;
    nx(); sym("bp.pend", 8'hAA, 2'd0, 1'b0, 1'b0);
    lanes_in = 32'h88776655;
    nx(); sym("bp.w3a", 8'hAA, 2'd0, 1'b0, 1'b0);
    nx(); sym("bp.w3b", 8'hAA, 2'd0, 1'b0, 1'b0); out_ready = 1'b1;
    nx(); sym("bp.bb", 8'hBB, 2'd1, 1'b0, 1'b0);
    nx(); sym("bp.cc", 8'hCC, 2'd2, 1'b0, 1'b0);
    nx(); sym("bp.dd", 8'hDD, 2'd3, 1'b1, 1'b0);
    nx(); sym("bp.11", 8'h11, 2'd0, 1'b0, 1'b1);
    nx(); sym("bp.22", 8'h22, 2'd1, 1'b0, 1'b0); in_valid = 1'b0;
    nx(); sym("bp.33", 8'h33, 2'd2, 1'b0, 1'b0);
    nx(); sym("bp.44", 8'h44, 2'd3, 1'b1, 1'b0);
    nx(); sym("bp.55", 8'h55, 2'd0, 1'b0, 1'b1);
    nx(); sym("bp.66", 8'h66, 2'd1, 1'b0, 1'b1);
    nx(); sym("bp.77", 8'h77, 2'd2, 1'b0, 1'b1);
    nx(); sym("bp.88", 8'h88, 2'd3, 1'b1, 1'b1);
    nx(); idle("bp.end");

    // active_lanes=2, changed mid-word without effect, then 0 meaning all four
    lanes_in = 32'hDDCCBBAA; active_lanes = 3'd2; in_valid = 1'b1;
    nx(); sym("al2.aa", 8'hAA, 2'd0, 1'b0, 1'b1); in_valid = 1'b0; active_lanes = 3'd4;
    nx(); sym("al2.bb", 8'hBB, 2'd1, 1'b1, 1'b1);
    nx(); idle("al2.end");
    active_lanes = 3'd0; in_valid = 1'b1;
    nx(); sym("al0.aa", 8'hAA, 2'd0, 1'b0, 1'b1); in_valid = 1'b0;
    nx(); sym("al0.bb", 8'hBB, 2'd1, 1'b0, 1'b1);
    nx(); sym("al0.cc", 8'hCC, 2'd2, 1'b0, 1'b1);
    nx(); sym("al0.dd", 8'hDD, 2'd3, 1'b1, 1'b1);
    nx(); idle("al0.end");
    // single lane: lane 0 only, last on every symbol; 5 clamps to 4
    active_lanes = 3'd1; in_valid = 1'b1;
    nx(); sym("al1.a", 8'hAA, 2'd0, 1'b1, 1'b1); lanes_in = 32'h44332211;
    nx(); sym("al1.b", 8'h11, 2'd0, 1'b1, 1'b1); active_lanes = 3'd5; lanes_in = 32'hDDCCBBAA;
    nx(); sym("al5.aa", 8'hAA, 2'd0, 1'b0, 1'b1); in_valid = 1'b0;
    nx(); sym("al5.bb", 8'hBB, 2'd1, 1'b0, 1'b1);
    nx(); sym("al5.cc", 8'hCC, 2'd2, 1'b0, 1'b1);
    nx(); sym("al5.dd", 8'hDD, 2'd3, 1'b1, 1'b1);
    nx(); idle("al5.end");

    // reset mid-word with PENDING full
    active_lanes = 3'd4; lanes_in = 32'hDDCCBBAA; in_valid = 1'b1;
    nx(); sym("rm.aa", 8'hAA, 2'd0, 1'b0, 1'b1); lanes_in = 32'h44332211;
    nx(); sym("rm.bb", 8'hBB, 2'd1, 1'b0, 1'b0); in_valid = 1'b0;
    #2 reset_L = 1'b0;
    #1 idle("rm.async");
    chk("rm.dat", 32'(out_data), 32'h00);
    nx(); reset_L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nx(); idle("rm.after");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
